// File: rtl/ev22_seq_pkg.sv
// Shared definitions for the EV22 fetch/execute sequencer: state encoding,
// opcode class match patterns and the NOP word.
package ev22_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Jump classes match on ir[15:11], BSR on ir[15:10], RET on ir[15:8].
  localparam logic [4:0] OP_JMP = 5'b00100;
  localparam logic [4:0] OP_JZE = 5'b00101;
  localparam logic [4:0] OP_JNE = 5'b00110;
  localparam logic [4:0] OP_JCY = 5'b00111;
  localparam logic [5:0] OP_BSR = 6'b000111;
  localparam logic [7:0] OP_RET = 8'b01000001;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/ev22_ret_stack.sv
// Return-address LIFO: push on full overwrites the top entry, pop on empty leaves
// the pointer at zero and dout reads 0. Only the pointer is reset.
module ev22_ret_stack #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW:0]   sp;
  logic [PW-1:0] top_idx;

  assign full    = (sp == (PW+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = PW'(sp - 1'b1);
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[full ? top_idx : sp[PW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push) begin
      if (!full) sp <= sp + 1'b1;
    end else if (pop) begin
      if (!empty) sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/ev22_pc_sequencer.sv
// EV22 fetch/decode/execute sequencer: PC, instruction register and return stack.
// Optional single-step port and WAIT state with EV22_SEQ_STEP_EN.
module ev22_pc_sequencer
  import ev22_seq_pkg::*;
#(
  parameter int                ADDR_W      = 11,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       ir,
  output logic              exec_en,
  input  logic              stall,
  input  logic              flag_z,
  input  logic              flag_w15,
  input  logic              flag_cy,
`ifdef EV22_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              stk_err,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef EV22_SEQ_STEP_EN
  localparam state_t ST_IDLE = ST_WAIT;
`else
  localparam state_t ST_IDLE = ST_FETCH;
`endif

  state_t            state;
  logic              commit;
  logic              is_jmp, is_jze, is_jne, is_jcy, is_bsr, is_ret;
  logic              push, pop;
  logic [ADDR_W-1:0] next_pc, pc_inc, bsr_off, stk_top;
  logic              stk_full, stk_empty;

  assign rom_addr = pc;
  assign commit   = (state == ST_EXEC) && !stall;
  assign pc_inc   = pc + ONE;
  assign bsr_off  = ADDR_W'($signed(ir[9:0]));

  assign is_jmp = (ir[15:11] == OP_JMP);
  assign is_jze = (ir[15:11] == OP_JZE);
  assign is_jne = (ir[15:11] == OP_JNE);
  assign is_jcy = (ir[15:11] == OP_JCY);
  assign is_bsr = (ir[15:10] == OP_BSR);
  assign is_ret = (ir[15:8]  == OP_RET);

  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    if (is_jmp || (is_jze && flag_z) || (is_jne && !flag_w15) || (is_jcy && flag_cy)) begin
      next_pc = ir[ADDR_W-1:0];
    end else if (is_bsr) begin
      next_pc = pc + bsr_off;
      push    = commit;
    end else if (is_ret) begin
      next_pc = stk_top + ONE;
      pop     = commit;
    end
  end

  ev22_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      ir      <= NOP_WORD;
      exec_en <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      if ((push && stk_full) || (pop && stk_empty)) stk_err <= 1'b1;
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          ir      <= rom_data;
          exec_en <= 1'b1;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          // exec_en stays high through stalled cycles; pc moves only on commit
          if (!stall) begin
            pc      <= next_pc;
            exec_en <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
`ifdef EV22_SEQ_STEP_EN
          if (step) state <= ST_FETCH;
`else
          state <= ST_FETCH;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ev22_pc_sequencer.sv
// Directed bench for ev22_pc_sequencer with a registered program ROM model.
module tb_ev22_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] rom_data;
  logic [10:0] rom_addr;
  logic [15:0] ir;
  logic        exec_en;
  logic        stall;
  logic        flag_z, flag_w15, flag_cy;
  logic        stk_err;
  logic [10:0] pc;
`ifdef EV22_SEQ_STEP_EN
  logic        step;
`endif

  logic [15:0] rom [0:2047];
  int checks = 0;
  int errors = 0;

  ev22_pc_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .ir       (ir),
    .exec_en  (exec_en),
    .stall    (stall),
    .flag_z   (flag_z),
    .flag_w15 (flag_w15),
    .flag_cy  (flag_cy),
`ifdef EV22_SEQ_STEP_EN
    .step     (step),
`endif
    .stk_err  (stk_err),
    .pc       (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until the EXEC strobe is seen, bounded.
  task automatic to_exec(input string tag);
    int n = 0;
    while (exec_en !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_reach_exec"}, exec_en, 1);
  endtask

  task automatic step_commit(input string tag, input logic [10:0] exp_pc);
    tick();
    check(tag, pc, exp_pc);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;
    reset = 1'b1; stall = 1'b0;
    flag_z = 1'b0; flag_w15 = 1'b0; flag_cy = 1'b0;
`ifdef EV22_SEQ_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_exec_en", exec_en, 0);
    check("rst_stk_err", stk_err, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;

`ifdef EV22_SEQ_STEP_EN
    begin
      int n_exec = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (exec_en) n_exec++;
      end
      check("step_low_no_exec", n_exec, 0);
      check("step_low_pc", pc, 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      n_exec = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (exec_en) n_exec++;
      end
      check("step_one_exec", n_exec, 1);
      check("step_one_pc", pc, 1);
    end
`else
    // NOP stream: exec_en on every third cycle, pc advancing after each EXEC
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("nop_exec_en_%0d", i), exec_en, (i % 3 == 2));
      check($sformatf("nop_pc_%0d", i), pc, i / 3);
    end
    stall = 1'b1;
    reset = 1'b1;
    tick();
    check("midexec_rst_pc", pc, 0);
    check("midexec_rst_exec_en", exec_en, 0);
    stall = 1'b0;

    rom[11'h000] = 16'h2123;  // JMP 0x123
    rom[11'h123] = 16'h2010;  // JMP 0x010
    rom[11'h010] = 16'h2850;  // JZE 0x050
    rom[11'h011] = 16'h2850;  // JZE 0x050
    rom[11'h050] = 16'h3060;  // JNE 0x060
    rom[11'h051] = 16'h3820;  // JCY 0x020
    rom[11'h020] = 16'h1C08;  // BSR +8
    rom[11'h028] = 16'h4100;  // RET
    rom[11'h021] = 16'h2000;  // JMP 0x000
    rom[11'h001] = 16'h4100;  // RET
    reset = 1'b0;

    to_exec("jmp");
    check("jmp_ir", ir, 16'h2123);
    rom[11'h000] = 16'h1FFF;  // BSR -1
    tick();
    check("jmp_rom_addr", rom_addr, 11'h123);
    to_exec("jmp2");
    step_commit("jmp2_pc", 11'h010);
    to_exec("jze_nz");
    flag_z = 1'b0;
    step_commit("jze_fall", 11'h011);
    to_exec("jze_z");
    flag_z = 1'b1;
    step_commit("jze_take", 11'h050);
    flag_z = 1'b0;
    to_exec("jne");
    flag_w15 = 1'b1;
    step_commit("jne_fall", 11'h051);
    flag_w15 = 1'b0;
    to_exec("jcy");
    flag_cy = 1'b1;
    step_commit("jcy_take", 11'h020);
    flag_cy = 1'b0;
    to_exec("bsr8");
    step_commit("bsr_plus8", 11'h028);
    to_exec("ret");
    step_commit("ret_pc", 11'h021);
    to_exec("jmp0");
    step_commit("jmp0_pc", 11'h000);

    // BSR -1 at 0x000 repeatedly: wraps to 0x7FF, NOP wraps back to 0x000
    for (int k = 1; k <= 5; k++) begin
      to_exec($sformatf("bsr_neg_%0d", k));
      if (k == 5) rom[11'h7FF] = 16'h4100;
      step_commit($sformatf("bsr_neg_pc_%0d", k), 11'h7FF);
      check($sformatf("bsr_stk_err_%0d", k), stk_err, (k == 5));
      if (k < 5) begin
        to_exec($sformatf("nop_wrap_%0d", k));
        step_commit($sformatf("wrap_pc_%0d", k), 11'h000);
      end
    end
    to_exec("ret_7ff");
    step_commit("ret_7ff_pc", 11'h001);
    for (int k = 1; k <= 4; k++) begin
      to_exec($sformatf("ret_pop_%0d", k));
      if (k == 4) rom[11'h001] = 16'h0000;
      step_commit($sformatf("ret_pop_pc_%0d", k), 11'h001);
      check($sformatf("ret_stk_err_%0d", k), stk_err, 1);
    end

    to_exec("stall");
    stall = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check($sformatf("stall_exec_en_%0d", j), exec_en, 1);
      check($sformatf("stall_pc_%0d", j), pc, 11'h001);
    end
    stall = 1'b0;
    tick();
    check("stall_release_exec_en", exec_en, 0);
    check("stall_release_pc", pc, 11'h002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
